// File: rtl/sram_port_arbiter_if.sv
// Purpose: bundles per-master SRAM request fields with the arbiter's grant and SRAM port outputs.
// Latency: none; this file only declares the wires and their direction per side.
// Backpressure: a master keeps req high for as long as it owns the SRAM; gnt is its only go signal.
interface sram_port_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 256
);
    logic [NUM_MASTERS-1:0]        req;
    logic [NUM_MASTERS*ADDR_W-1:0] m_rd_addr1;
    logic [NUM_MASTERS*ADDR_W-1:0] m_rd_addr2;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] m_wr_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wr_data;

    logic [NUM_MASTERS-1:0]        gnt;
    logic [2:0]                    gnt_id;
    logic                          busy;
    logic [ADDR_W-1:0]             sram_rd_addr1;
    logic [ADDR_W-1:0]             sram_rd_addr2;
    logic [ADDR_W-1:0]             sram_wr_addr;
    logic                          sram_we;
    logic [DATA_W-1:0]             sram_wr_data;

    // Requester side: drives requests and its SRAM fields, observes the grant and the shared port.
    modport master (
        output req, m_rd_addr1, m_rd_addr2, m_we, m_wr_addr, m_wr_data,
        input  gnt, gnt_id, busy, sram_rd_addr1, sram_rd_addr2, sram_wr_addr, sram_we, sram_wr_data
    );

    // Arbiter side: the mirror image of the requester view.
    modport slave (
        input  req, m_rd_addr1, m_rd_addr2, m_we, m_wr_addr, m_wr_data,
        output gnt, gnt_id, busy, sram_rd_addr1, sram_rd_addr2, sram_wr_addr, sram_we, sram_wr_data
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: grants one of NUM_MASTERS requesters exclusive use of the SRAM ports (macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority).
// Latency: grant registered one cycle after req; SRAM port outputs are a same-cycle mux of the owner's inputs.
// Backpressure: owner keeps the port while req stays high, unless MAX_HOLD expires with another master waiting.
module sram_port_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 256,
    parameter int MAX_HOLD    = 0
) (
    input  logic               clk,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);
    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t                 state;
    state_t                 nextState;
    logic [NUM_MASTERS-1:0] gntQ;
    logic [2:0]             gntIdQ;
    logic                   busyQ;
    logic [HOLD_W-1:0]      holdCnt;
    logic [NUM_MASTERS-1:0] others;
    logic [NUM_MASTERS-1:0] candidates;
    logic                   holdExpired;
    logic                   rotate;
    logic                   winFound;
    logic                   loadGrant;
    logic [IDX_W-1:0]       winIdx;
    int                     searchStart;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       lastOwner;
`endif

    // First set bit of cand, scanning upward from start and wrapping around.
    function automatic logic [IDX_W-1:0] firstSet(input logic [NUM_MASTERS-1:0] cand, input int start);
        logic [IDX_W-1:0] idx;
        logic             hit;
        int               j;
        idx = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = (start + k) % NUM_MASTERS;
            if (!hit && cand[IDX_W'(j)]) begin
                hit = 1'b1;
                idx = IDX_W'(j);
            end
        end
        return idx;
    endfunction

    // Hold counter saturates, so ">=" keeps the limit sticky until someone else asks.
    assign holdExpired = (MAX_HOLD > 0) && (int'(holdCnt) >= MAX_HOLD);

    // Next-state and winner selection; the owner is masked out whenever it is giving up the port.
    always_comb begin
        others     = bus.req & ~gntQ;
        candidates = bus.req;
        rotate     = 1'b0;
        nextState  = state;
        case (state)
            IDLE: begin
                if (|bus.req) nextState = OWNED;
            end
            OWNED: begin
                candidates = others;
                rotate     = (~|(bus.req & gntQ)) || (holdExpired && (|others));
                if (rotate && (~|others)) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        searchStart = (int'(lastOwner) + 1) % NUM_MASTERS;
`else
        searchStart = 0;
`endif
        winIdx    = firstSet(candidates, searchStart);
        winFound  = |candidates;
        loadGrant = winFound && ((state == IDLE) || rotate);
    end

    // State register with grant, owner index and hold bookkeeping, all moving on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            gntQ      <= '0;
            gntIdQ    <= '0;
            busyQ     <= 1'b0;
            holdCnt   <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            lastOwner <= IDX_W'(NUM_MASTERS - 1);
`endif
        end else begin
            state <= nextState;
            if (loadGrant) begin
                gntQ      <= NUM_MASTERS'(1) << winIdx;
                gntIdQ    <= 3'(winIdx);
                busyQ     <= 1'b1;
                holdCnt   <= HOLD_W'(1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                lastOwner <= winIdx;
`endif
            end else if (nextState == IDLE) begin
                gntQ    <= '0;
                gntIdQ  <= '0;
                busyQ   <= 1'b0;
                holdCnt <= '0;
            end else if (~&holdCnt) begin
                holdCnt <= holdCnt + 1'b1;
            end
        end
    end

    assign bus.gnt    = gntQ;
    assign bus.gnt_id = gntIdQ;
    assign bus.busy   = busyQ;

    // SRAM port mux driven by the registered grant; idle values whenever nobody owns it or reset is low.
    always_comb begin
        bus.sram_rd_addr1 = '1;
        bus.sram_rd_addr2 = '1;
        bus.sram_wr_addr  = '1;
        bus.sram_we       = 1'b0;
        bus.sram_wr_data  = '0;
        if (reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (gntQ[i]) begin
                    bus.sram_rd_addr1 = bus.m_we[i] ? '1 : bus.m_rd_addr1[i*ADDR_W +: ADDR_W];
                    bus.sram_rd_addr2 = bus.m_rd_addr2[i*ADDR_W +: ADDR_W];
                    bus.sram_wr_addr  = bus.m_wr_addr[i*ADDR_W +: ADDR_W];
                    bus.sram_we       = bus.m_we[i];
                    bus.sram_wr_data  = bus.m_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose: checks two arbiters (MAX_HOLD=0 and MAX_HOLD=3) against an ownership model and literal vectors.
// Latency: model advances on each rising edge; outputs are compared on the falling edge.
// Backpressure: stimulus is fixed-step; no waits on DUT events.
module tb_sram_port_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [43:0]  rd1Bus;
    logic [43:0]  rd2Bus;
    logic [43:0]  wrBus;
    logic [1023:0] dataBus;

    int  checks = 0;
    int  errors = 0;
    bit  chkEn  = 1'b0;

    int owner   [2] = '{-1, -1};
    int last    [2] = '{3, 3};
    int hold    [2] = '{0, 0};
    int maxHold [2] = '{0, 3};

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(11), .DATA_W(256)) ifA ();
    sram_port_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(11), .DATA_W(256)) ifB ();

    assign ifA.req = req;        assign ifB.req = req;
    assign ifA.m_we = we;        assign ifB.m_we = we;
    assign ifA.m_rd_addr1 = rd1Bus; assign ifB.m_rd_addr1 = rd1Bus;
    assign ifA.m_rd_addr2 = rd2Bus; assign ifB.m_rd_addr2 = rd2Bus;
    assign ifA.m_wr_addr = wrBus;   assign ifB.m_wr_addr = wrBus;
    assign ifA.m_wr_data = dataBus; assign ifB.m_wr_data = dataBus;

    sram_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(11), .DATA_W(256), .MAX_HOLD(0)) dutA (
        .clk(clk), .reset(reset), .bus(ifA)
    );
    sram_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(11), .DATA_W(256), .MAX_HOLD(3)) dutB (
        .clk(clk), .reset(reset), .bus(ifB)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] cand, input int start);
        int j;
        for (int k = 0; k < 4; k++) begin
            j = (start + k) % 4;
            if (cand[2'(j)]) return j;
        end
        return -1;
    endfunction

    // Ownership model: who owns the port after this edge, from the selection and release rules.
    always @(posedge clk) begin : model
        logic [3:0] oth;
        int s, w, o, l, h;
        for (int m = 0; m < 2; m++) begin
            o = owner[m]; l = last[m]; h = hold[m];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            s = (l + 1) % 4;
`else
            s = 0;
`endif
            if (!reset) begin
                o = -1; l = 3; h = 0;
            end else if (o < 0) begin
                w = pick(req, s);
                if (w >= 0) begin o = w; l = w; h = 1; end
            end else begin
                oth = req & ~(4'b0001 << o);
                if (!req[2'(o)] || (maxHold[m] > 0 && h >= maxHold[m] && oth != 4'b0)) begin
                    w = pick(oth, s);
                    if (w >= 0) begin o = w; l = w; h = 1; end
                    else begin o = -1; h = 0; end
                end else begin
                    h = h + 1;
                end
            end
            owner[m] <= o; last[m] <= l; hold[m] <= h;
        end
    end

    task automatic cmpInst(input int m, input string p, input logic [3:0] g, input logic [2:0] id,
                           input logic b, input logic [10:0] r1, input logic [10:0] r2,
                           input logic [10:0] wa, input logic w, input logic [255:0] d);
        int o;
        logic [3:0] eG; logic [2:0] eId; logic eB, eW;
        logic [10:0] eR1, eR2, eWa; logic [255:0] eD;
        o   = owner[m];
        eG  = (o < 0) ? 4'b0 : (4'b0001 << o);
        eId = (o < 0) ? 3'd0 : 3'(o);
        eB  = (o >= 0);
        eR1 = 11'h7ff; eR2 = 11'h7ff; eWa = 11'h7ff; eW = 1'b0; eD = '0;
        if (reset && o >= 0) begin
            eW  = we[2'(o)];
            eR1 = eW ? 11'h7ff : rd1Bus[o*11 +: 11];
            eR2 = rd2Bus[o*11 +: 11];
            eWa = wrBus[o*11 +: 11];
            eD  = dataBus[o*256 +: 256];
        end
        chk({p, "gnt"}, g, eG);
        chk({p, "onehot"}, $onehot0(g), 1);
        chk({p, "gnt_id"}, id, eId);
        chk({p, "busy"}, b, eB);
        chk({p, "rd_addr1"}, r1, eR1);
        chk({p, "rd_addr2"}, r2, eR2);
        chk({p, "wr_addr"}, wa, eWa);
        chk({p, "we"}, w, eW);
        chk({p, "wr_data"}, d, eD);
    endtask

    // Per-cycle comparison of both arbiters against the model, away from the active edge.
    always @(negedge clk) begin
        if (chkEn) begin
            cmpInst(0, "A.", ifA.gnt, ifA.gnt_id, ifA.busy, ifA.sram_rd_addr1, ifA.sram_rd_addr2,
                    ifA.sram_wr_addr, ifA.sram_we, ifA.sram_wr_data);
            cmpInst(1, "B.", ifB.gnt, ifB.gnt_id, ifB.busy, ifB.sram_rd_addr1, ifB.sram_rd_addr2,
                    ifB.sram_wr_addr, ifB.sram_we, ifB.sram_wr_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic scramble();
        rd1Bus = {12'($urandom), $urandom};
        rd2Bus = {12'($urandom), $urandom};
        wrBus  = {12'($urandom), $urandom};
        for (int i = 0; i < 32; i++) dataBus[i*32 +: 32] = $urandom;
    endtask

    logic [3:0] pats [20] = '{4'b0011, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b1101,
                              4'b1100, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1011,
                              4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req = 4'b0; we = 4'b0;
        scramble();
        step(); step();
        chkEn = 1'b1;
        chk("reset_gnt", ifA.gnt, 4'b0);
        chk("reset_busy", ifA.busy, 1'b0);

        // Reset release, nobody requesting
        reset = 1'b1;
        step();
        chk("idle_gnt", ifA.gnt, 4'b0);
        chk("idle_busy", ifA.busy, 1'b0);
        chk("idle_rd1", ifA.sram_rd_addr1, 11'h7ff);
        chk("idle_rd2", ifA.sram_rd_addr2, 11'h7ff);
        chk("idle_we", ifA.sram_we, 1'b0);

        // Two requesters, then owner releases with no dead cycle
        req = 4'b1010;
        step();
        chk("first_gnt", ifA.gnt, 4'b0010);
        chk("first_gntB", ifB.gnt, 4'b0010);
        req = 4'b1000;
        step();
        chk("handoff_gnt", ifA.gnt, 4'b1000);
        chk("handoff_id", ifA.gnt_id, 3'd3);

        // Owner 2 writing: port 1 read address forced high
        scramble();
        req = 4'b0100; we = 4'b0100;
        wrBus[22 +: 11] = 11'h123; rd1Bus[22 +: 11] = 11'h045;
        step();
        chk("wr_gnt", ifA.gnt, 4'b0100);
        chk("wr_we", ifA.sram_we, 1'b1);
        chk("wr_addr", ifA.sram_wr_addr, 11'h123);
        chk("wr_rd1", ifA.sram_rd_addr1, 11'h7ff);

        // Reset during a master 3 write
        req = 4'b1000; we = 4'b1000;
        step();
        chk("m3_we", ifA.sram_we, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_we_now", ifA.sram_we, 1'b0);
        step();
        chk("rst_gnt", ifA.gnt, 4'b0);
        chk("rst_we", ifA.sram_we, 1'b0);
        reset = 1'b1; req = 4'b1111; we = 4'b0;
        step();
        chk("post_rst_gnt", ifA.gnt, 4'b0001);
        chk("post_rst_gntB", ifB.gnt, 4'b0001);

        // Hold limit: master 0 held while master 3 waits
        reset = 1'b0; req = 4'b0;
        step();
        reset = 1'b1; req = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_gntB", ifB.gnt, 4'b0001);
        end
        step();
        chk("hold_rotB", ifB.gnt, 4'b1000);
        chk("hold_keepA", ifA.gnt, 4'b0001);

        // Owner 1 blips its request while master 2 waits
        reset = 1'b0; req = 4'b0;
        step();
        reset = 1'b1; req = 4'b0110;
        step();
        chk("blip_gnt1", ifA.gnt, 4'b0010);
        req = 4'b0100;
        step();
        chk("blip_gnt2", ifA.gnt, 4'b0100);
        req = 4'b0110;
        step();
        chk("blip_keep2", ifA.gnt, 4'b0100);
        req = 4'b0010;
        step();
        chk("blip_back1", ifA.gnt, 4'b0010);

        // Directed pattern table with scrambled non-owner data
        foreach (pats[i]) begin
            scramble();
            we  = 4'($urandom);
            req = pats[i];
            step();
        end
        for (int i = 0; i < 60; i++) begin
            scramble();
            we    = 4'($urandom);
            req   = 4'($urandom);
            reset = (i != 30);
            step();
        end
        reset = 1'b1; req = 4'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters, legal range 2..8.
REQ-002 Parameter ADDR_W, default 11: SRAM address width.
REQ-003 Parameter DATA_W, default 256: SRAM write-data width.
REQ-004 Parameter MAX_HOLD, default 0: maximum consecutive grant cycles while other masters wait; 0 means unlimited.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 req  input  NUM_MASTERS  per-master request; held high for the whole ownership.
REQ-008 m_rd_addr1, m_rd_addr2  input  NUM_MASTERS*ADDR_W  per-master read addresses; master i occupies slice [i*ADDR_W +: ADDR_W].
REQ-009 m_we  input  NUM_MASTERS  per-master write enable.
REQ-010 m_wr_addr  input  NUM_MASTERS*ADDR_W  per-master write address.
REQ-011 m_wr_data  input  NUM_MASTERS*DATA_W  per-master write data.
REQ-012 gnt  output  NUM_MASTERS  registered one-hot grant vector.
REQ-013 gnt_id  output  3  registered index of the current owner; 0 when idle.
REQ-014 busy  output  1  registered; high while any grant is active.
REQ-015 sram_rd_addr1, sram_rd_addr2, sram_wr_addr  output  ADDR_W  SRAM port addresses.
REQ-016 sram_we  output  1  SRAM write enable.
REQ-017 sram_wr_data  output  DATA_W  SRAM write data.

Function
REQ-018 The FSM SHALL have two states: IDLE (gnt zero) and OWNED (exactly one gnt bit high).
REQ-019 In IDLE, if any req bit is high at edge t, the winner SHALL be selected per REQ-020 and gnt SHALL be high from edge t+1 (one-cycle grant latency).
REQ-020 Winner selection SHALL be round-robin: search starts at index (last_owner+1) mod NUM_MASTERS; after reset, last_owner = NUM_MASTERS-1, so master 0 has first priority.
REQ-021 In OWNED, when the owner's req is low at edge t, the grant SHALL transfer at t+1 directly to the next winner among the other requesters, or the FSM SHALL return to IDLE if none request; no dead cycle is permitted.
REQ-022 Re-requests by the same master SHALL pass through selection again and SHALL lose to any other pending requester.
REQ-023 When MAX_HOLD>0, the hold counter SHALL count owner cycles from 1; when it reaches MAX_HOLD and another req is high, the grant SHALL rotate at the next edge regardless of the owner's req. The counter SHALL reset on every grant change.
REQ-024 The SRAM port outputs SHALL be a combinational mux of the owner's inputs, selected by the registered gnt.
REQ-025 While the owner drives m_we=1, sram_rd_addr1 SHALL be forced to all-ones, avoiding a read/write collision on port 1.
REQ-026 When idle, sram_rd_addr1, sram_rd_addr2 and sram_wr_addr SHALL be all-ones, and sram_we and sram_wr_data SHALL be 0.
REQ-027 The design SHALL guarantee that gnt is at most one-hot in every cycle.
REQ-028 Inputs of non-owners SHALL have no effect on any output.

Reset
REQ-029 While reset=0 at a clock edge: state IDLE, gnt=0, gnt_id=0, busy=0, hold counter 0, last_owner=NUM_MASTERS-1; SRAM outputs SHALL take the idle values of REQ-026 in the same cycle.
REQ-030 Reset asserted mid-ownership SHALL drop the grant at that edge; any in-flight write SHALL be abandoned, with sram_we=0 at the reset edge.

Configuration
REQ-031 Macro SRAM_ARB_ROUND_ROBIN_EN defined: selection SHALL follow REQ-020 and REQ-022.
REQ-032 Macro SRAM_ARB_ROUND_ROBIN_EN undefined: selection SHALL be fixed priority, with the lowest index winning; last_owner SHALL not be implemented; REQ-022 and MAX_HOLD rotation SHALL still exclude the current owner on that cycle only.

Verification
REQ-033 Reset release with req=4'b0000 -> gnt=0, busy=0, sram_rd_addr1=11'h7ff, sram_rd_addr2=11'h7ff, sram_we=0.
REQ-034 req=4'b1010 asserted at edge t -> gnt=4'b0010 at t+1; master 1 drops req -> gnt=4'b1000 on the next edge with no idle cycle.
REQ-035 Owner 2 drives m_we=1, m_wr_addr=11'h123, m_rd_addr1=11'h045 -> sram_we=1, sram_wr_addr=11'h123, sram_rd_addr1=11'h7ff.
REQ-036 MAX_HOLD=3, master 0 holds req with req[3] also high -> gnt=4'b0001 for exactly 3 cycles, then gnt=4'b1000.
REQ-037 reset=0 while master 3 is writing -> at that edge gnt=0 and sram_we=0; after release with req=4'b1111 -> gnt=4'b0001.
REQ-038 With SRAM_ARB_ROUND_ROBIN_EN undefined, req=4'b0110 held, owner 1 toggles req low for one cycle -> gnt goes 4'b0100, then returns to 4'b0010 once master 2 releases.
